// File: rtl/tbus_arbiter.sv
// Round-robin owner arbiter for a shared tristate bus: one-hot registered
// enables, a hold limit per tenure, and an all-off turnaround between tenures.
module tbus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);

    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [7:0]      hold_q;
    logic [2:0]      turn_q;
    logic [N-1:0]    gnt_q;
    logic [N-1:0]    en_q;
    logic [PW-1:0]   owner_q;
    logic            busy_q;

    logic            win_found_d;
    logic [PW-1:0]   win_idx_d;
    logic [N-1:0]    win_oh_d;
    logic [PW-1:0]   ptr_d;
    logic            grant_d;

    // Two passes give the search order ptr..N-1 then 0..ptr-1 without a modulo.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        win_found_d = 1'b0;
        win_idx_d   = '0;
        win_oh_d    = '0;
        for (int i = 0; i < N; i++) begin
            if (!win_found_d && i >= int'(ptr_q) && req[i]) begin
                win_found_d = 1'b1;
                win_idx_d   = PW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!win_found_d && req[i]) begin
                win_found_d = 1'b1;
                win_idx_d   = PW'(i);
            end
        end
        win_oh_d[win_idx_d] = 1'b1;

        ptr_d   = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
        grant_d = win_found_d &&
                  ((state_q == IDLE) || (state_q == TURN && turn_q == 3'(TURN_CYC)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            gnt_q   <= '0;
            en_q    <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            case (state_q)
                IDLE: begin
                    hold_q <= '0;
                end
                DRIVE: begin
                    if (!req[owner_q] || hold_q == 8'(MAX_HOLD)) begin
                        state_q <= TURN;
                        ptr_q   <= ptr_d;
                        hold_q  <= '0;
                        turn_q  <= 3'd1;
                        gnt_q   <= '0;
                        en_q    <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                TURN: begin
                    if (turn_q == 3'(TURN_CYC)) begin
                        state_q <= IDLE;
                        turn_q  <= '0;
                    end else begin
                        turn_q <= turn_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A new tenure overrides the IDLE fall-through taken at the end of TURN.
            if (grant_d) begin
                state_q <= DRIVE;
                hold_q  <= 8'd1;
                gnt_q   <= win_oh_d;
                en_q    <= win_oh_d;
                owner_q <= win_idx_d;
                busy_q  <= 1'b1;
            end
        end
    end

    assign gnt   = gnt_q;
    assign en    = en_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Directed and random self-checking bench for tbus_arbiter (N=4, MAX_HOLD=8, TURN_CYC=1).
module tb_tbus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int TURN_CYC = 1;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] en;
    logic [1:0]   owner;
    logic         busy;

    int n_checks;
    int n_pass;
    int cyc;

    tbus_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD),
        .TURN_CYC (TURN_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .en    (en),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and land 1 time unit after it; cyc names the cycle now visible.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Leaves the bench at cycle 0: the first edge after reset release has passed.
    task automatic apply_reset();
        req   = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = -1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (en !== 4'b0000) $display("FAIL reset_en: got %b want 0000", en);
        else n_pass++;
        n_checks++;
        if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
        n_checks++;
        if (owner !== 2'd0) $display("FAIL reset_owner: got %0d want 0", owner);
        else n_pass++;
        n_checks++;
        if (dut.ptr_q !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q);
        else n_pass++;
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_single_grant();
        apply_reset();
        req = 4'b0001;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || en !== 4'b0001)
            $display("FAIL single_grant: gnt=%b en=%b want 0001/0001", gnt, en);
        else n_pass++;
        n_checks++;
        if (owner !== 2'd0 || busy !== 1'b1)
            $display("FAIL single_owner: owner=%0d busy=%b want 0/1", owner, busy);
        else n_pass++;
        req = 4'b0000;
        step();
        n_checks++;
        if (en !== 4'b0000 || busy !== 1'b0)
            $display("FAIL single_release: en=%b busy=%b want 0000/0", en, busy);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_en;
        int           slot;
        apply_reset();
        req = 4'b1111;
        for (int c = 1; c <= 40; c++) begin
            step();
            // Nine-cycle slots from cycle 1: eight cycles of one owner, then one off.
            slot   = (c - 1) / 9;
            exp_en = ((c - 1) % 9 < 8) ? (4'b0001 << (slot % 4)) : 4'b0000;
            n_checks++;
            if (en !== exp_en || gnt !== exp_en)
                $display("FAIL round_robin c%0d: en=%b gnt=%b want %b", c, en, gnt, exp_en);
            else n_pass++;
        end
        req = '0;
    endtask

    task automatic test_early_drop();
        logic [N-1:0] exp_en;
        apply_reset();
        req = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            step();
            exp_en = (c <= 3) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (en !== exp_en) $display("FAIL early_drop c%0d: en=%b want %b", c, en, exp_en);
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if (owner !== 2'd2) $display("FAIL early_drop_owner: got %0d want 2", owner);
                else n_pass++;
            end
            if (c == 3) req = 4'b0000;
        end
        n_checks++;
        if (dut.ptr_q !== 2'd3) $display("FAIL early_drop_ptr: got %0d want 3", dut.ptr_q);
        else n_pass++;
    endtask

    task automatic test_handover();
        logic [N-1:0] exp_en;
        apply_reset();
        req = 4'b0011;
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_en = (c <= 5) ? 4'b0001 : (c == 6) ? 4'b0000 : 4'b0010;
            n_checks++;
            if (en !== exp_en) $display("FAIL handover c%0d: en=%b want %b", c, en, exp_en);
            else n_pass++;
            if (c == 5) req = 4'b0010;
        end
        req = '0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_en;
        apply_reset();
        req = 4'b0001;
        for (int c = 1; c <= 27; c++) begin
            step();
            exp_en = ((c - 1) % 9 < 8) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (en !== exp_en) $display("FAIL back_to_back c%0d: en=%b want %b", c, en, exp_en);
            else n_pass++;
        end
        req = '0;
    endtask

    task automatic test_reset_mid_drive();
        apply_reset();
        req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            step();
            n_checks++;
            if (en !== 4'b0010) $display("FAIL mid_reset_pre c%0d: en=%b want 0010", c, en);
            else n_pass++;
        end
        reset = 1'b1;
        step();
        n_checks++;
        if (en !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0)
            $display("FAIL mid_reset_drop: en=%b gnt=%b busy=%b want 0000/0000/0", en, gnt, busy);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (en !== 4'b0010 || owner !== 2'd1)
            $display("FAIL mid_reset_regrant: en=%b owner=%0d want 0010/1", en, owner);
        else n_pass++;
        req = '0;
    endtask

    // Leave ptr at 3, then reset: requester 0 must beat requester 3.
    task automatic test_ptr_after_reset();
        apply_reset();
        req = 4'b0100;
        step();
        req = 4'b0000;
        repeat (3) step();
        n_checks++;
        if (dut.ptr_q !== 2'd3) $display("FAIL ptr_setup: got %0d want 3", dut.ptr_q);
        else n_pass++;
        apply_reset();
        req = 4'b1001;
        step();
        n_checks++;
        if (en !== 4'b0001 || owner !== 2'd0)
            $display("FAIL ptr_after_reset: en=%b owner=%0d want 0001/0", en, owner);
        else n_pass++;
        req = '0;
    endtask

    task automatic test_random();
        logic [N-1:0] prev_en;
        int           zero_run;
        int           on_run;
        bit           seen_grant;
        apply_reset();
        prev_en    = '0;
        zero_run   = 0;
        on_run     = 0;
        seen_grant = 1'b0;
        for (int c = 1; c <= 10000; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            step();
            n_checks++;
            if ($countones(en) > 1) $display("FAIL rand_onehot c%0d: en=%b", c, en);
            else n_pass++;
            n_checks++;
            if (gnt !== en || busy !== (en != '0))
                $display("FAIL rand_gnt_busy c%0d: gnt=%b en=%b busy=%b", c, gnt, en, busy);
            else n_pass++;
            if (en != '0) begin
                on_run++;
                n_checks++;
                if (on_run > MAX_HOLD || en !== (4'b0001 << owner))
                    $display("FAIL rand_tenure c%0d: run=%0d en=%b owner=%0d max=%0d",
                             c, on_run, en, owner, MAX_HOLD);
                else n_pass++;
                if (prev_en != '0) begin
                    n_checks++;
                    if (en !== prev_en)
                        $display("FAIL rand_switch c%0d: en=%b after %b with no gap", c, en, prev_en);
                    else n_pass++;
                end else if (seen_grant) begin
                    n_checks++;
                    if (zero_run < TURN_CYC)
                        $display("FAIL rand_turnaround c%0d: gap=%0d want >=%0d", c, zero_run, TURN_CYC);
                    else n_pass++;
                end
                seen_grant = 1'b1;
                zero_run   = 0;
            end else begin
                on_run = 0;
                zero_run++;
            end
            prev_en = en;
        end
        req = '0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        reset    = 1'b1;
        req      = '0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_early_drop();
        test_handover();
        test_back_to_back();
        test_reset_mid_drive();
        test_ptr_after_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tbus_arbiter.md
TBUS_ARBITER -- requirements
Module: tbus_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one tristate bus, 2..8.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive cycles one owner may drive, 1..255.
REQ-003 Parameter TURN_CYC, default 1: all-off turnaround cycles between owners, 1..7.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N  per-requester bus request, level-sensitive.
REQ-007 gnt  output  N  one-hot grant to requester, registered.
REQ-008 en  output  N  tristate-buffer enables, one per requester driver, registered.
REQ-009 owner  output  clog2(N)  index of current owner; valid only while busy=1.
REQ-010 busy  output  1  high while any en bit is high.

Function
REQ-011 The FSM SHALL have states IDLE, DRIVE and TURN; the round-robin pointer ptr SHALL be clog2(N) bits.
REQ-012 IDLE: en=0, gnt=0; if any req bit is sampled high, the next state SHALL be DRIVE for the winner i, with gnt[i]=en[i]=1 in the next cycle (one-cycle latency).
REQ-013 Winner SHALL be the first requester with req high, searching ptr, ptr+1, ..., wrapping modulo N.
REQ-014 DRIVE: gnt and en SHALL stay equal and one-hot for the owner; owner=i; busy=1.
REQ-015 DRIVE SHALL end when req[i] is sampled low, or when en[i] has been high for MAX_HOLD cycles; en and gnt SHALL be 0 in the following cycle.
REQ-016 On leaving DRIVE, ptr SHALL become (i+1) mod N and the next state SHALL be TURN.
REQ-017 TURN SHALL last exactly TURN_CYC cycles with en=0 and gnt=0; req sampled in the last TURN cycle SHALL be arbitrated per REQ-013 and go directly to DRIVE, otherwise go to IDLE.
REQ-018 Between any two different owners, and between consecutive tenures of the same owner, en SHALL be all-zero for at least TURN_CYC cycles; no bus contention is permitted.
REQ-019 At most one en bit SHALL be high in any cycle.
REQ-020 A preempted requester that keeps req high SHALL re-arbitrate normally; with other requests pending, it loses by pointer rotation.
REQ-021 req changes of non-owners during DRIVE, and any req changes in TURN before its last cycle, SHALL be ignored.
REQ-022 The hold counter SHALL saturate-free count 1..MAX_HOLD and clear on every new grant.

Reset
REQ-023 While reset is sampled high: state=IDLE, ptr=0, hold and turn counters=0; gnt=0, en=0, owner=0, busy=0 from the next edge.
REQ-024 Reset asserted during DRIVE SHALL drop en to 0 at the next edge with no turnaround state; the first grant after reset SHALL follow REQ-012 with requester 0 at highest priority.

Verification (N=4, MAX_HOLD=8, TURN_CYC=1; cycle 0 = first edge after reset release)
REQ-025 req=0001 sampled at cycle 0 -> gnt=en=0001, owner=0, busy=1 at cycle 1.
REQ-026 req=1111 held continuously -> en=0001 cycles 1-8, 0000 at 9, 0010 cycles 10-17, 0000 at 18, 0100 at 19-26, 0000 at 27, 1000 at 28-35, then 0001 again.
REQ-027 req=0100 for cycles 0-2 only -> en=0100 cycles 1-3, en=0000 from cycle 4, ptr=3.
REQ-028 req=0011 held, req[0] dropped at cycle 5 -> en=0001 cycles 1-5, 0000 at 6, 0010 from cycle 7.
REQ-029 req=0001 held forever -> repeating pattern of 8 cycles en=0001 and 1 cycle en=0000.
REQ-030 reset pulsed at cycle 4 during DRIVE with req=0010 still high -> en=0000 at cycle 5; new grant en=0010 the cycle after reset is released.
REQ-031 A bench assertion SHALL check REQ-018 and REQ-019 every cycle across a 10000-cycle random req run.
